// File: rtl/timer_pkg.sv
// +--------------------------------------------------------------------------+
// | timer_pkg : shared types and constants for the mmio_timer register block  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Word offsets, i.e. addr[3:2]
  localparam logic [1:0] c_OFF_CTRL   = 2'd0;
  localparam logic [1:0] c_OFF_PRESET = 2'd1;
  localparam logic [1:0] c_OFF_COUNT  = 2'd2;
  localparam logic [1:0] c_OFF_UNMAP  = 2'd3;

  localparam int c_CTRL_EN       = 0;
  localparam int c_CTRL_MODE_LSB = 1;
  localparam int c_CTRL_IM       = 3;
  localparam int c_CTRL_W        = 4;

  localparam logic [1:0] c_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] c_MODE_RELOAD  = 2'b01;

  // Only 01 reloads; 00 and both 1x encodings behave as one-shot.
  function automatic logic is_reload(input logic [1:0] i_mode);
    return (i_mode == c_MODE_RELOAD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_merge.sv
// +--------------------------------------------------------------------------+
// | byte_merge : per-lane replace of a 32-bit word under byte enables         |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module byte_merge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_byteen,
  output logic [31:0] o_merged
);

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      assign o_merged[8*k +: 8] = i_byteen[k] ? i_wdata[8*k +: 8] : i_old[8*k +: 8];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// +--------------------------------------------------------------------------+
// | mmio_timer : memory-mapped countdown timer with CTRL/PRESET/COUNT and irq |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module mmio_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CTRL_W-1:0] r_ctrl;
  logic [31:0]         r_preset;
  logic [31:0]         r_count;
  logic                r_irq_flag;

  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [31:0] w_old;
  logic [31:0] w_merged;
  logic        w_en;
  logic [1:0]  w_mode;

  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;
  logic w_flag_set;
  logic w_flag_clr;
  logic w_en_clr;

  assign w_sel  = addr[3:2];
  assign hit    = (addr[31:4] == BASE_ADDR[31:4]) && (w_sel != c_OFF_UNMAP);
  assign w_wr   = hit && (|byteen);
  assign w_wr_ctrl   = w_wr && (w_sel == c_OFF_CTRL);
  assign w_wr_preset = w_wr && (w_sel == c_OFF_PRESET);

  assign w_en   = r_ctrl[c_CTRL_EN];
  assign w_mode = r_ctrl[c_CTRL_MODE_LSB +: 2];

  // One merge unit serves both writable registers; its old word follows the target.
  assign w_old = (w_sel == c_OFF_CTRL) ? {{(32-c_CTRL_W){1'b0}}, r_ctrl} : r_preset;

  byte_merge u_merge (
    .i_old    (w_old),
    .i_wdata  (wdata),
    .i_byteen (byteen),
    .o_merged (w_merged)
  );

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (w_sel)
        c_OFF_CTRL:   rdata = {{(32-c_CTRL_W){1'b0}}, r_ctrl};
        c_OFF_PRESET: rdata = r_preset;
        c_OFF_COUNT:  rdata = r_count;
        default:      rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_zero  = 1'b0;
    w_flag_set  = 1'b0;
    w_flag_clr  = 1'b0;
    w_en_clr    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_cnt_load  = 1'b1;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_cnt_dec = 1'b1;
        end else begin
          // PRESET of 0 lands here too, so it expires like PRESET of 1.
          w_cnt_zero  = 1'b1;
          w_flag_set  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (is_reload(w_mode)) begin
          w_flag_clr  = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_en_clr    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus writes to CTRL take priority over FSM-driven EN and flag updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= w_merged[c_CTRL_W-1:0];
      end else if (w_en_clr) begin
        r_ctrl[c_CTRL_EN] <= 1'b0;
      end

      if (w_wr_preset) begin
        r_preset <= w_merged;
      end

      if (w_cnt_load) begin
        r_count <= r_preset;
      end else if (w_cnt_dec) begin
        r_count <= r_count - 32'd1;
      end else if (w_cnt_zero) begin
        r_count <= '0;
      end

      if (w_wr_ctrl) begin
        r_irq_flag <= 1'b0;
      end else if (w_flag_set) begin
        r_irq_flag <= 1'b1;
      end else if (w_flag_clr) begin
        r_irq_flag <= 1'b0;
      end
    end
  end

  assign irq = r_irq_flag & r_ctrl[c_CTRL_IM];

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// +--------------------------------------------------------------------------+
// | tb_mmio_timer : scoreboard bench for the mmio_timer register block        |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mmio_timer;

  localparam logic [31:0] c_BASE  = 32'h0000_7F00;
  localparam logic [31:0] c_A_CTL = c_BASE;
  localparam logic [31:0] c_A_PRE = c_BASE + 32'd4;
  localparam logic [31:0] c_A_CNT = c_BASE + 32'd8;
  localparam logic [31:0] c_A_UNM = c_BASE + 32'd12;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  typedef struct packed {
    logic [31:0] count;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mmio_timer #(.BASE_ADDR(c_BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
    wdata  = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      bus_read(c_BASE + 32'(4 * i), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h want 00000000", i, v);
      end
    end
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
    bus_read(c_A_UNM, v);
    n_cmp++;
    if (hit !== 1'b0 || v !== 32'h0) begin
      n_err++;
      $display("FAIL reset_unmapped: hit=%b rdata=%h want hit=0 rdata=0", hit, v);
    end
    bus_read(c_A_CTL, v);
    n_cmp++;
    if (hit !== 1'b1) begin
      n_err++;
      $display("FAIL decode_hit: got %b want 1", hit);
    end
  endtask

  task automatic test_partial_write;
    logic [31:0] v;
    bus_write(c_A_PRE, 32'h1122_3344, 4'b1111);
    bus_write(c_A_PRE, 32'hAA00_0000, 4'b1000);
    bus_read(c_A_PRE, v);
    n_cmp++;
    if (v !== 32'hAA22_3344) begin
      n_err++;
      $display("FAIL partial_preset: got %h want aa223344", v);
    end
    bus_write(c_A_CNT, 32'hFFFF_FFFF, 4'b1111);
    bus_read(c_A_CNT, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL count_readonly: got %h want 00000000", v);
    end
    // Upper CTRL bits are not stored.
    bus_write(c_A_CTL, 32'hFFFF_FFF0, 4'b1111);
    bus_read(c_A_CTL, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL ctrl_upper: got %h want 00000000", v);
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    exp_t        e;
    int          k;
    bus_write(c_A_PRE, 32'd3, 4'b1111);
    bus_write(c_A_CTL, 32'h9, 4'b1111);
    // Entries are the state after edges E, E+1, ... E+6.
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd3, irq: 1'b0});
    sb_q.push_back('{count: 32'd2, irq: 1'b0});
    sb_q.push_back('{count: 32'd1, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b1});
    sb_q.push_back('{count: 32'd0, irq: 1'b1});
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL oneshot_E+%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    bus_read(c_A_CTL, v);
    n_cmp++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL oneshot_en_clear: ctrl=%h want 00000008", v);
    end
    repeat (3) step();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL oneshot_irq_hold: got %b want 1", irq);
    end
    bus_write(c_A_CTL, 32'h8, 4'b0001);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_irq_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_autoreload;
    logic [31:0] v;
    exp_t        e;
    int          k;
    int          ph;
    bus_write(c_A_PRE, 32'd2, 4'b1111);
    bus_write(c_A_CTL, 32'hB, 4'b1111);
    // Period is PRESET+2: load, count down, one-cycle INT.
    for (int i = 0; i <= 16; i++) begin
      ph = (i - 2) % 4;
      e.count = (i < 2) ? 32'd0 : (ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0;
      e.irq   = (i >= 4) && (i % 4 == 0);
      sb_q.push_back(e);
    end
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL reload_E+%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    bus_write(c_A_CTL, 32'h0, 4'b1111);
    repeat (4) step();
  endtask

  task automatic test_masked;
    logic [31:0] v;
    exp_t        e;
    int          k;
    bus_write(c_A_PRE, 32'd2, 4'b1111);
    bus_write(c_A_CTL, 32'h1, 4'b1111);
    repeat (2) step();
    sb_q.push_back('{count: 32'd2, irq: 1'b0});
    sb_q.push_back('{count: 32'd1, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    k = 2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL masked_E+%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    bus_read(c_A_CTL, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL masked_idle: ctrl=%h want 00000000", v);
    end
  endtask

  task automatic test_preset_zero;
    logic [31:0] v;
    exp_t        e;
    int          k;
    bus_write(c_A_PRE, 32'd0, 4'b1111);
    bus_write(c_A_CTL, 32'h9, 4'b1111);
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b0});
    sb_q.push_back('{count: 32'd0, irq: 1'b1});
    sb_q.push_back('{count: 32'd0, irq: 1'b1});
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL zero_E+%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    bus_write(c_A_CTL, 32'h0, 4'b1111);
    step();
  endtask

  task automatic test_disable_reset;
    logic [31:0] v;
    exp_t        e;
    int          k;
    bus_write(c_A_PRE, 32'd10, 4'b1111);
    bus_write(c_A_CTL, 32'h9, 4'b1111);
    repeat (2) step();
    for (int i = 0; i < 5; i++) sb_q.push_back('{count: 32'(10 - i), irq: 1'b0});
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL run10_%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    // The disabling edge still decrements 6->5; COUNT then holds.
    bus_write(c_A_CTL, 32'h8, 4'b1111);
    for (int i = 0; i < 5; i++) sb_q.push_back('{count: 32'd5, irq: 1'b0});
    sb_q.push_back('{count: 32'd5, irq: 1'b0});
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL hold_%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    bus_write(c_A_CTL, 32'h9, 4'b1111);
    sb_q.push_back('{count: 32'd5,  irq: 1'b0});
    sb_q.push_back('{count: 32'd5,  irq: 1'b0});
    sb_q.push_back('{count: 32'd10, irq: 1'b0});
    sb_q.push_back('{count: 32'd9,  irq: 1'b0});
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bus_read(c_A_CNT, v);
      n_cmp++;
      if (v !== e.count || irq !== e.irq) begin
        n_err++;
        $display("FAIL reenable_R+%0d: count=%h irq=%b want count=%h irq=%b", k, v, irq, e.count, e.irq);
      end
      k++;
      if (sb_q.size() > 0) step();
    end
    repeat (9) step();
    bus_read(c_A_CNT, v);
    n_cmp++;
    if (v !== 32'd0 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL expire10: count=%h irq=%b want count=0 irq=1", v, irq);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq_async: got %b want 0", irq);
    end
    @(negedge clk);
    reset = 1'b1;
    bus_write(c_A_PRE, 32'd10, 4'b1111);
    bus_write(c_A_CTL, 32'h9, 4'b1111);
    repeat (4) step();
    bus_read(c_A_CNT, v);
    n_cmp++;
    if (v !== 32'd8) begin
      n_err++;
      $display("FAIL midcount: count=%h want 00000008", v);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_read(c_BASE + 32'(4 * i), v);
      n_cmp++;
      if (v !== 32'h0) begin
        n_err++;
        $display("FAIL midreset_reg%0d: got %h want 00000000", i, v);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    bus_read(c_A_CNT, v);
    n_cmp++;
    if (v !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: count=%h irq=%b want 0/0", v, irq);
    end
  endtask

  initial begin
    addr   = '0;
    wdata  = '0;
    byteen = 4'b0000;
    reset  = 1'b0;
    test_reset();
    test_partial_write();
    test_oneshot();
    test_autoreload();
    test_masked();
    test_preset_zero();
    test_disable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
